array_param: RTL and testbench

ARRAY_PARAM -- requirements
Module: array_param

---
 rtl/array_param.sv | 117 +++++++++++
 tb/tb_array_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_param.sv
// Parameterised register array with power-up table, two registered read ports
// and one write port, sequenced by an IDLE -> INIT -> ACTIVE state machine.
module array_param #(
    parameter int                      DATA_W    = 16,
    parameter int                      DEPTH     = 8,
    parameter int                      ADDR_W    = 3,
    parameter bit                      BYPASS    = 1'b0,
    parameter logic [DEPTH*DATA_W-1:0] INIT_VALS = {16'd99, 16'd13, 16'd46, 16'd120,
                                                    16'd13, 16'd85, 16'd175, 16'd236}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              reinit,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_idx_a,
    input  logic [ADDR_W-1:0] rd_idx_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_a,
    output logic              rd_valid_b,
    output logic              ready,
    output logic              idx_err
);
    typedef enum logic [1:0] {IDLE, INIT, ACTIVE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic                   acc, wr_ok;
    logic [1:0]             rd_en, rd_vld_nxt, rd_bad;
    logic [1:0][ADDR_W-1:0] rd_idx;
    logic [1:0][DATA_W-1:0] rd_nxt;

    function automatic logic in_range(input logic [ADDR_W-1:0] i);
        return 32'(i) < 32'(DEPTH);
    endfunction

    // reinit wins over any access issued in the same cycle
    assign acc   = (state == ACTIVE) && en && !reinit;
    assign wr_ok = acc && wr_en && in_range(wr_idx);
    assign ready = (state == ACTIVE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            INIT: begin
                if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ACTIVE;
                else                           cnt_nxt   = cnt + 1'b1;
            end
            ACTIVE: begin
                if (en && reinit) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // contents are left alone by reset; INIT overwrites every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == INIT) mem[cnt]    <= INIT_VALS[int'(cnt)*DATA_W +: DATA_W];
            else if (wr_ok)    mem[wr_idx] <= wr_data;
        end
    end

    assign rd_en  = {rd_en_b, rd_en_a};
    assign rd_idx = {rd_idx_b, rd_idx_a};

    for (genvar g = 0; g < 2; g++) begin : g_rd
        logic hit;
        assign hit           = BYPASS && wr_ok && (wr_idx == rd_idx[g]);
        assign rd_vld_nxt[g] = acc && rd_en[g] && in_range(rd_idx[g]);
        assign rd_bad[g]     = acc && rd_en[g] && !in_range(rd_idx[g]);
        assign rd_nxt[g]     = !rd_vld_nxt[g] ? '0 : (hit ? wr_data : mem[rd_idx[g]]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            idx_err    <= 1'b0;
        end else begin
            rd_data_a  <= rd_nxt[0];
            rd_data_b  <= rd_nxt[1];
            rd_valid_a <= rd_vld_nxt[0];
            rd_valid_b <= rd_vld_nxt[1];
            idx_err    <= (|rd_bad) || (acc && wr_en && !in_range(wr_idx));
        end
    end
endmodule

// File: tb/tb_array_param.sv
// Bench for array_param: three instances (depth 8, depth 8 with bypass, depth 6)
// share stimulus and are each compared every cycle against a behavioural model.
module tb_array_param;
    logic        clk = 1'b0, reset = 1'b0, en = 1'b0, reinit = 1'b0;
    logic        wr_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
    logic [2:0]  wr_idx = '0, rd_idx_a = '0, rd_idx_b = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] da [3], db [3];
    logic        va [3], vb [3], rdy [3], err [3];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    array_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b0)) u0 (
        .clk(clk), .reset(reset), .en(en), .reinit(reinit), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_idx_a(rd_idx_a),
        .rd_idx_b(rd_idx_b), .rd_data_a(da[0]), .rd_data_b(db[0]), .rd_valid_a(va[0]),
        .rd_valid_b(vb[0]), .ready(rdy[0]), .idx_err(err[0]));
    array_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b1)) u1 (
        .clk(clk), .reset(reset), .en(en), .reinit(reinit), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_idx_a(rd_idx_a),
        .rd_idx_b(rd_idx_b), .rd_data_a(da[1]), .rd_data_b(db[1]), .rd_valid_a(va[1]),
        .rd_valid_b(vb[1]), .ready(rdy[1]), .idx_err(err[1]));
    array_param #(.DATA_W(16), .DEPTH(6), .ADDR_W(3), .BYPASS(1'b0),
                  .INIT_VALS({16'd46, 16'd120, 16'd13, 16'd85, 16'd175, 16'd236})) u2 (
        .clk(clk), .reset(reset), .en(en), .reinit(reinit), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_idx_a(rd_idx_a),
        .rd_idx_b(rd_idx_b), .rd_data_a(da[2]), .rd_data_b(db[2]), .rd_valid_a(va[2]),
        .rd_valid_b(vb[2]), .ready(rdy[2]), .idx_err(err[2]));

    // reference model: 0 idle, 1 loading, 2 active
    int          dep [3] = '{8, 8, 6};
    bit          byp [3] = '{1'b0, 1'b1, 1'b0};
    int          iv  [8] = '{236, 175, 85, 13, 120, 46, 13, 99};
    int          m_st [3] = '{0, 0, 0};
    int          m_cnt [3] = '{0, 0, 0};
    logic [15:0] m_mem [3][8];
    logic [15:0] e_da [3], e_db [3];
    logic        e_va [3], e_vb [3], e_err [3];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic mstep(input int k);
        int   d;
        logic acc, wok, aok, bok;
        d = dep[k];
        e_da[k] = '0; e_db[k] = '0; e_va[k] = 1'b0; e_vb[k] = 1'b0; e_err[k] = 1'b0;
        if (!reset) begin
            m_st[k] = 0; m_cnt[k] = 0;
            return;
        end
        acc = (m_st[k] == 2) && en && !reinit;
        wok = acc && wr_en && (int'(wr_idx) < d);
        aok = acc && rd_en_a && (int'(rd_idx_a) < d);
        bok = acc && rd_en_b && (int'(rd_idx_b) < d);
        if (aok) begin
            e_va[k] = 1'b1;
            e_da[k] = (byp[k] && wok && wr_idx == rd_idx_a) ? wr_data : m_mem[k][rd_idx_a];
        end
        if (bok) begin
            e_vb[k] = 1'b1;
            e_db[k] = (byp[k] && wok && wr_idx == rd_idx_b) ? wr_data : m_mem[k][rd_idx_b];
        end
        e_err[k] = acc && ((wr_en && int'(wr_idx) >= d) || (rd_en_a && int'(rd_idx_a) >= d) ||
                           (rd_en_b && int'(rd_idx_b) >= d));
        if (wok) m_mem[k][wr_idx] = wr_data;
        case (m_st[k])
            0: if (en) begin m_st[k] = 1; m_cnt[k] = 0; end
            1: begin
                m_mem[k][m_cnt[k]] = 16'(iv[m_cnt[k]]);
                m_cnt[k]++;
                if (m_cnt[k] == d) m_st[k] = 2;
            end
            default: if (en && reinit) begin m_st[k] = 1; m_cnt[k] = 0; end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) mstep(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("m_rd_data_a", k, da[k], e_da[k]);
            chk("m_rd_data_b", k, db[k], e_db[k]);
            chk("m_rd_valid_a", k, va[k], e_va[k]);
            chk("m_rd_valid_b", k, vb[k], e_vb[k]);
            chk("m_idx_err", k, err[k], e_err[k]);
            chk("m_ready", k, rdy[k], m_st[k] == 2);
        end
    endtask

    task automatic quiet();
        reinit = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    task automatic init_timing(input string nm);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk({nm, "_ready8"}, 0, rdy[0], i == 8);
            chk({nm, "_ready6"}, 2, rdy[2], i >= 6);
        end
    endtask

    task automatic readback(input string nm);
        rd_en_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_idx_a = 3'(i);
            cyc();
            chk({nm, "_data8"}, 0, da[0], iv[i]);
            chk({nm, "_valid8"}, 0, va[0], 1);
            chk({nm, "_data6"}, 2, da[2], (i < 6) ? iv[i] : 0);
            chk({nm, "_err6"}, 2, err[2], i >= 6);
        end
        rd_en_a = 1'b0;
    endtask

    typedef struct {
        logic en, wr_en; logic [2:0] wi; logic [15:0] wd;
        logic ra; logic [2:0] ia; logic rb; logic [2:0] ib;
        logic [15:0] eda; logic eva; logic [15:0] edb; logic evb; logic [15:0] eda_byp;
    } vec_t;
    vec_t tbl [9];

    initial begin
        // u0/u1 contents before the table: 236,175,85,13,120,46,13,dead
        tbl[0] = '{1, 0, 0, 16'h0000, 1, 0, 1, 7, 16'd236, 1, 16'hdead, 1, 16'd236};
        tbl[1] = '{1, 1, 5, 16'hbeef, 1, 3, 1, 3, 16'd13, 1, 16'd13, 1, 16'd13};
        tbl[2] = '{1, 0, 0, 16'h0000, 1, 5, 1, 0, 16'hbeef, 1, 16'd236, 1, 16'hbeef};
        tbl[3] = '{1, 1, 2, 16'h1234, 1, 2, 1, 2, 16'd85, 1, 16'd85, 1, 16'h1234};
        tbl[4] = '{1, 0, 0, 16'h0000, 1, 2, 0, 0, 16'h1234, 1, 16'd0, 0, 16'h1234};
        tbl[5] = '{0, 1, 0, 16'hffff, 1, 1, 1, 1, 16'd0, 0, 16'd0, 0, 16'd0};
        tbl[6] = '{1, 0, 0, 16'h0000, 1, 0, 1, 1, 16'd236, 1, 16'd175, 1, 16'd236};
        tbl[7] = '{1, 1, 0, 16'h8001, 0, 0, 1, 0, 16'd0, 0, 16'd236, 1, 16'd0};
        tbl[8] = '{1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h8001, 1, 16'd0, 0, 16'h8001};

        reset = 1'b0;
        cyc(); cyc();
        chk("rst_ready", 0, rdy[0], 0);
        chk("rst_valid", 0, va[0], 0);
        chk("rst_err", 2, err[2], 0);

        reset = 1'b1; en = 1'b1;
        cyc();
        en = 1'b0; rd_en_a = 1'b1; wr_en = 1'b1;   // ignored while loading
        init_timing("init");
        quiet(); en = 1'b1;
        readback("init_rd");

        wr_en = 1'b1; wr_idx = 3'd7; wr_data = 16'hdead;
        cyc();
        chk("oor_wr_err", 2, err[2], 1);
        quiet();
        cyc();
        chk("err_one_cycle", 2, err[2], 0);
        rd_en_a = 1'b1; rd_idx_a = 3'd6;
        cyc();
        chk("oor_rd_data", 2, da[2], 0);
        chk("oor_rd_valid", 2, va[2], 0);
        chk("oor_rd_err", 2, err[2], 1);
        rd_en_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_idx_a = 3'(i);
            cyc();
            chk("d6_unchanged", 2, da[2], iv[i]);
        end
        quiet();

        for (int i = 0; i < 9; i++) begin
            en = tbl[i].en; wr_en = tbl[i].wr_en; wr_idx = tbl[i].wi; wr_data = tbl[i].wd;
            rd_en_a = tbl[i].ra; rd_idx_a = tbl[i].ia; rd_en_b = tbl[i].rb; rd_idx_b = tbl[i].ib;
            cyc();
            chk("tbl_da", i, da[0], tbl[i].eda);
            chk("tbl_va", i, va[0], tbl[i].eva);
            chk("tbl_db", i, db[0], tbl[i].edb);
            chk("tbl_vb", i, vb[0], tbl[i].evb);
            chk("tbl_da_bypass", i, da[1], tbl[i].eda_byp);
        end
        quiet(); en = 1'b1;

        reinit = 1'b1; rd_en_a = 1'b1; rd_idx_a = 3'd0;
        cyc();
        chk("reinit_prio_valid", 0, va[0], 0);
        chk("reinit_ready", 0, rdy[0], 0);
        reinit = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rd_idx_a = 3'(i % 8);
            cyc();
            chk("reinit_rd_valid", 0, va[0], 0);
            chk("reinit_rd_data", 0, da[0], 0);
            chk("reinit_ready8", 0, rdy[0], i == 8);
        end
        quiet();
        readback("reinit_rd");

        wr_en = 1'b1; wr_data = 16'h0;
        for (int i = 0; i < 8; i++) begin wr_idx = 3'(i); cyc(); end
        quiet();
        reset = 1'b0; cyc();
        reset = 1'b1; en = 1'b1; cyc();
        en = 1'b0; cyc(); cyc(); cyc();
        reset = 1'b0; cyc();
        chk("abort_ready", 0, rdy[0], 0);
        reset = 1'b1; cyc();
        chk("abort_idle_ready", 0, rdy[0], 0);
        en = 1'b1; cyc();
        init_timing("restart");
        readback("restart_rd");

        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(99) != 0);
            en       = ($urandom_range(9) != 0);
            reinit   = ($urandom_range(49) == 0);
            wr_en    = 1'($urandom_range(1));
            wr_idx   = 3'($urandom_range(7));
            wr_data  = 16'($urandom);
            rd_en_a  = 1'($urandom_range(1));
            rd_en_b  = 1'($urandom_range(1));
            rd_idx_a = ($urandom_range(3) == 0) ? wr_idx : 3'($urandom_range(7));
            rd_idx_b = 3'($urandom_range(7));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
